// File: rtl/fft_bitrev_collector.sv
// rtl/fft_bitrev_collector.sv - ping-pong reorder buffer from bit-reversed FFT output to natural bin order
// Optional: define FFT_COLLECT_DROP_CNT_EN to add the drop_cnt saturating dropped-frame counter.
module fft_bitrev_collector #(
  parameter int N     = 32,
  parameter int LOG2N = 5,
  parameter int DW    = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [DW-1:0]    in_re,
  input  logic signed [DW-1:0]    in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DW-1:0]    out_re,
  output logic signed [DW-1:0]    out_im,
  output logic [LOG2N-1:0]        out_idx,
  output logic                    out_last,
  output logic                    overflow,
`ifdef FFT_COLLECT_DROP_CNT_EN
  output logic [7:0]              drop_cnt,
`endif
  input  logic                    ovf_clr
);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
  typedef enum logic [1:0] {B_EMPTY, B_FULL, B_DRAIN} bank_t;

  localparam logic [LOG2N-1:0] IDX_ONE  = LOG2N'(1);
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  // Bank select is the MSB of the address: bank 0 at 0..N-1, bank 1 at N..2N-1
  logic [2*DW-1:0]  mem [2*N];

  wstate_t          wstate;
  bank_t            bank_st [2];
  logic             wbank;
  logic             rbank;
  logic [LOG2N-1:0] wcnt;

  logic             xfer;
  logic             last_xfer;
  logic             start_ok;
  logic             drop_start;
  logic             mem_we;
  logic [LOG2N:0]   waddr;
  logic             rd_load;
  logic             rd_bank;
  logic [LOG2N-1:0] rd_addr;
  logic [2*DW-1:0]  rd_word;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
    return r;
  endfunction

  // Write-side decode; a bank being released by out_last this cycle counts as free
  always_comb begin
    xfer       = out_valid & out_ready;
    last_xfer  = xfer & out_last;
    start_ok   = (bank_st[wbank] == B_EMPTY) || (last_xfer && (rbank == wbank));
    drop_start = in_valid && (wstate == W_IDLE) && !start_ok;
    mem_we     = in_valid && (((wstate == W_IDLE) && start_ok) || (wstate == W_FILL));
    // wcnt is 0 in IDLE and bitrev(0) = 0, so one address expression covers both states
    waddr      = {wbank, bitrev(wcnt)};
  end

  // Read-side source selection: continue the current bank, or hop to the other bank on out_last
  always_comb begin
    rd_load = 1'b0;
    rd_bank = rbank;
    rd_addr = '0;
    if (last_xfer) begin
      rd_bank = ~rbank;
      rd_load = (bank_st[~rbank] == B_FULL);
    end else if (xfer) begin
      rd_load = 1'b1;
      rd_addr = out_idx + IDX_ONE;
    end else if (!out_valid && (bank_st[rbank] == B_FULL)) begin
      rd_load = 1'b1;
    end
    rd_word = mem[{rd_bank, rd_addr}];
  end

  // Sample storage; contents need no reset because bank state gates every read
  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr] <= {in_re, in_im};
  end

  // Write FSM, bank bookkeeping, overflow flag and registered output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate     <= W_IDLE;
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      wcnt       <= '0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
`ifdef FFT_COLLECT_DROP_CNT_EN
      drop_cnt   <= '0;
`endif
    end else begin
      case (wstate)
        W_IDLE: begin
          if (in_valid) begin
            wcnt   <= IDX_ONE;
            wstate <= start_ok ? W_FILL : W_DROP;
          end
        end
        W_FILL: begin
          if (in_valid) begin
            if (wcnt == LAST_IDX) begin
              bank_st[wbank] <= B_FULL;
              wbank          <= ~wbank;
              wcnt           <= '0;
              wstate         <= W_IDLE;
            end else begin
              wcnt <= wcnt + IDX_ONE;
            end
          end
        end
        W_DROP: begin
          if (in_valid) begin
            if (wcnt == LAST_IDX) begin
              wcnt   <= '0;
              wstate <= W_IDLE;
            end else begin
              wcnt <= wcnt + IDX_ONE;
            end
          end
        end
        default: wstate <= W_IDLE;
      endcase

      // A drop in the same cycle as a clear keeps the flag set
      if (ovf_clr)    overflow <= 1'b0;
      if (drop_start) overflow <= 1'b1;

`ifdef FFT_COLLECT_DROP_CNT_EN
      if (ovf_clr)
        drop_cnt <= '0;
      else if (drop_start && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
`endif

      // The freed bank is never the bank completed by the writer, so both updates coexist
      if (last_xfer) begin
        bank_st[rbank] <= B_EMPTY;
        rbank          <= ~rbank;
      end

      if (rd_load) begin
        out_valid <= 1'b1;
        out_re    <= rd_word[2*DW-1:DW];
        out_im    <= rd_word[DW-1:0];
        out_idx   <= rd_addr;
        out_last  <= (rd_addr == LAST_IDX);
        if (rd_addr == '0) bank_st[rd_bank] <= B_DRAIN;
      end else if (last_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
